// File: rtl/fp16_divider.sv
// Sequential fp16 divider: one restoring step per clock, fixed 16-cycle start-to-done latency.
// Defining FP16_DIV_FLAGS_EN adds the {invalid,divzero,overflow,underflow,inexact} flags port.
module fp16_divider (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        busy,
    output logic        done,
    output logic [15:0] out
`ifdef FP16_DIV_FLAGS_EN
    ,
    output logic [4:0]  flags
`endif
);
    typedef enum logic [1:0] {IDLE, UNPACK, DIVIDE, ROUND} state_t;

    state_t             state;
    logic [15:0]        a_q;
    logic [15:0]        b_q;
    logic [3:0]         cnt;
    logic               sgn;
    logic signed [6:0]  exp_r;
    logic [10:0]        mb;
    logic [11:0]        rem;
    logic [12:0]        q;
    logic               sp_hit_r;
    logic [15:0]        sp_out_r;
    logic               fin;
    logic [15:0]        res;
`ifdef FP16_DIV_FLAGS_EN
    logic [4:0]         sp_fl_r;
    logic [4:0]         res_fl;
    logic [4:0]         sp_fl;
    logic [4:0]         rnd_fl;
`endif

    logic [4:0]         ea;
    logic [4:0]         eb;
    logic               nan_a;
    logic               nan_b;
    logic               inf_a;
    logic               inf_b;
    logic               zero_a;
    logic               zero_b;
    logic               is_inv;
    logic               is_dz;
    logic               sgn_n;
    logic [10:0]        ma_n;
    logic [10:0]        mb_n;
    logic signed [6:0]  exp_raw;
    logic               sp_hit;
    logic [15:0]        sp_out;

    always_comb begin
        ea      = a_q[14:10];
        eb      = b_q[14:10];
        zero_a  = (ea == 5'd0);
        zero_b  = (eb == 5'd0);
        nan_a   = (ea == 5'h1F) && (a_q[9:0] != 10'd0);
        nan_b   = (eb == 5'h1F) && (b_q[9:0] != 10'd0);
        inf_a   = (ea == 5'h1F) && (a_q[9:0] == 10'd0);
        inf_b   = (eb == 5'h1F) && (b_q[9:0] == 10'd0);
        sgn_n   = a_q[15] ^ b_q[15];
        ma_n    = zero_a ? 11'd0 : {1'b1, a_q[9:0]};
        mb_n    = zero_b ? 11'd0 : {1'b1, b_q[9:0]};
        exp_raw = {2'b00, ea} - {2'b00, eb} + 7'd15;
        is_inv  = nan_a | nan_b | (zero_a & zero_b) | (inf_a & inf_b);
        is_dz   = zero_b & ~inf_a & ~is_inv;
        sp_hit  = 1'b1;
        sp_out  = 16'h0000;
        if (is_inv)
            sp_out = 16'h7E00;
        else if (is_dz || inf_a)
            sp_out = {sgn_n, 15'h7C00};
        else if (inf_b || zero_a)
            sp_out = {sgn_n, 15'h0000};
        else
            sp_hit = 1'b0;
    end

`ifdef FP16_DIV_FLAGS_EN
    assign sp_fl = {is_inv, is_dz, 3'b000};
`endif

    logic [12:0]        diff;
    assign diff = {1'b0, rem} - {2'b00, mb};

    logic [10:0]        mant;
    logic               guard;
    logic               sticky;
    logic               rup;
    logic [11:0]        msum;
    logic               carry;
    logic [9:0]         frac;
    logic signed [7:0]  e_adj;
    logic               ovf;
    logic               unf;
    logic [15:0]        rnd_out;

    // A quotient below 1 is normalised by one left shift, costing one exponent step.
    always_comb begin
        mant   = q[12] ? q[12:2] : q[11:1];
        guard  = q[12] ? q[1] : q[0];
        sticky = (rem != 12'd0) | (q[12] & q[0]);
        rup    = guard & (sticky | mant[0]);
        msum   = {1'b0, mant} + {11'd0, rup};
        carry  = msum[11];
        frac   = carry ? msum[10:1] : msum[9:0];
        e_adj  = {exp_r[6], exp_r} - {7'd0, ~q[12]} + {7'd0, carry};
        ovf    = (e_adj >= 8'sd31);
        unf    = (e_adj <= 8'sd0);
        if (sp_hit_r)
            rnd_out = sp_out_r;
        else if (ovf)
            rnd_out = {sgn, 15'h7C00};
        else if (unf)
            rnd_out = {sgn, 15'h0000};
        else
            rnd_out = {sgn, e_adj[4:0], frac};
    end

`ifdef FP16_DIV_FLAGS_EN
    assign rnd_fl = sp_hit_r ? sp_fl_r
                  : {2'b00, ovf, unf, ovf | unf | guard | sticky};
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            out      <= 16'h0000;
            fin      <= 1'b0;
            res      <= 16'h0000;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            cnt      <= 4'd0;
            sgn      <= 1'b0;
            exp_r    <= 7'sd0;
            mb       <= 11'd0;
            rem      <= 12'd0;
            q        <= 13'd0;
            sp_hit_r <= 1'b0;
            sp_out_r <= 16'h0000;
`ifdef FP16_DIV_FLAGS_EN
            flags    <= 5'd0;
            sp_fl_r  <= 5'd0;
            res_fl   <= 5'd0;
`endif
        end else begin
            done <= 1'b0;
            // Result is published one edge after ROUND, while the FSM is already idle.
            if (fin) begin
                done  <= 1'b1;
                out   <= res;
                busy  <= 1'b0;
                fin   <= 1'b0;
`ifdef FP16_DIV_FLAGS_EN
                flags <= res_fl;
`endif
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        busy  <= 1'b1;
                        state <= UNPACK;
                    end
                end
                UNPACK: begin
                    sgn      <= sgn_n;
                    exp_r    <= exp_raw;
                    rem      <= {1'b0, ma_n};
                    mb       <= mb_n;
                    q        <= 13'd0;
                    cnt      <= 4'd0;
                    sp_hit_r <= sp_hit;
                    sp_out_r <= sp_out;
`ifdef FP16_DIV_FLAGS_EN
                    sp_fl_r  <= sp_fl;
`endif
                    state    <= DIVIDE;
                end
                DIVIDE: begin
                    q   <= {q[11:0], ~diff[12]};
                    rem <= (diff[12] ? rem : diff[11:0]) << 1;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd12)
                        state <= ROUND;
                end
                ROUND: begin
                    res    <= rnd_out;
`ifdef FP16_DIV_FLAGS_EN
                    res_fl <= rnd_fl;
`endif
                    fin    <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
